// File: rtl/thermo_quad_tx.sv
// ============================================================================
// Module   : thermo_quad_tx
// Purpose  : Transmit side of the 4-lane thermometer interface. Collects four
//            binary operands as a serial valid/ready stream, encodes each one
//            to a thermometer code and presents the four codes together, held
//            stable, on a valid/ready output handshake.
// Ports    : clk, rst_n          - clock (rising edge), async active-low reset
//            in_valid/in_ready   - operand handshake, in_bin carries operand
//            in_bin              - binary operand, beats 0..3 -> lanes 1..4
//            out_valid/out_ready - set handshake
//            out1..out4          - thermometer codes, lanes 1..4
//            exp_second          - second-largest operand of the set
//                                  (only when THERMO_EXPECT_EN is defined)
// Options  : THERMO_EXPECT_EN - adds exp_second and its sorting network.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module thermo_quad_tx #(
  parameter int BIN_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BIN_W-1:0]       in_bin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [(2**BIN_W)-2:0]  out1,
  output logic [(2**BIN_W)-2:0]  out2,
  output logic [(2**BIN_W)-2:0]  out3,
  output logic [(2**BIN_W)-2:0]  out4
`ifdef THERMO_EXPECT_EN
  ,
  output logic [BIN_W-1:0]       exp_second
`endif
);

  localparam int TW = (2**BIN_W) - 1;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          lane_cnt_q, lane_cnt_d;
  logic [BIN_W-1:0]    hold0_q, hold0_d;
  logic [BIN_W-1:0]    hold1_q, hold1_d;
  logic [BIN_W-1:0]    hold2_q, hold2_d;
  logic [TW-1:0]       out1_q, out1_d;
  logic [TW-1:0]       out2_q, out2_d;
  logic [TW-1:0]       out3_q, out3_d;
  logic [TW-1:0]       out4_q, out4_d;
  logic                accept;

  // Bit j is set iff j < v, so the code can never contain a bubble.
  function automatic logic [TW-1:0] therm(input logic [BIN_W-1:0] v);
    logic [TW-1:0] r;
    r = '0;
    for (int j = 0; j < TW; j++) begin
      r[j] = (j < int'(v));
    end
    return r;
  endfunction

`ifdef THERMO_EXPECT_EN
  logic [BIN_W-1:0]    exp_q, exp_d;

  function automatic logic [BIN_W-1:0] vmax(input logic [BIN_W-1:0] a,
                                            input logic [BIN_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [BIN_W-1:0] vmin(input logic [BIN_W-1:0] a,
                                            input logic [BIN_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Second-largest with duplicates counted: sort each pair, then the runner-up
  // is either the smaller of the two pair maxima or the larger of the two
  // pair minima, whichever is bigger.
  function automatic logic [BIN_W-1:0] second(input logic [BIN_W-1:0] a,
                                              input logic [BIN_W-1:0] b,
                                              input logic [BIN_W-1:0] c,
                                              input logic [BIN_W-1:0] d);
    logic [BIN_W-1:0] hi_ab, lo_ab, hi_cd, lo_cd;
    hi_ab = vmax(a, b);
    lo_ab = vmin(a, b);
    hi_cd = vmax(c, d);
    lo_cd = vmin(c, d);
    return vmax(vmin(hi_ab, hi_cd), vmax(lo_ab, lo_cd));
  endfunction
`endif

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == FULL);
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    hold0_d    = hold0_q;
    hold1_d    = hold1_q;
    hold2_d    = hold2_q;
    out1_d     = out1_q;
    out2_d     = out2_q;
    out3_d     = out3_q;
    out4_d     = out4_q;
`ifdef THERMO_EXPECT_EN
    exp_d      = exp_q;
`endif
    case (state_q)
      COLLECT: begin
        if (accept) begin
          case (lane_cnt_q)
            2'd0: begin
              hold0_d    = in_bin;
              lane_cnt_d = 2'd1;
            end
            2'd1: begin
              hold1_d    = in_bin;
              lane_cnt_d = 2'd2;
            end
            2'd2: begin
              hold2_d    = in_bin;
              lane_cnt_d = 2'd3;
            end
            default: begin
              // Last beat bypasses the holding registers so the whole set
              // lands on the output registers on this very edge.
              out1_d     = therm(hold0_q);
              out2_d     = therm(hold1_q);
              out3_d     = therm(hold2_q);
              out4_d     = therm(in_bin);
`ifdef THERMO_EXPECT_EN
              exp_d      = second(hold0_q, hold1_q, hold2_q, in_bin);
`endif
              lane_cnt_d = 2'd0;
              state_d    = FULL;
            end
          endcase
        end
      end
      FULL: begin
        // in_ready is low here, so no beat can be consumed; the release edge
        // itself cannot accept a beat either.
        if (out_ready) begin
          state_d = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      lane_cnt_q <= 2'd0;
      hold0_q    <= '0;
      hold1_q    <= '0;
      hold2_q    <= '0;
      out1_q     <= '0;
      out2_q     <= '0;
      out3_q     <= '0;
      out4_q     <= '0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      hold0_q    <= hold0_d;
      hold1_q    <= hold1_d;
      hold2_q    <= hold2_d;
      out1_q     <= out1_d;
      out2_q     <= out2_d;
      out3_q     <= out3_d;
      out4_q     <= out4_d;
    end
  end

`ifdef THERMO_EXPECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q <= '0;
    end else begin
      exp_q <= exp_d;
    end
  end

  assign exp_second = exp_q;
`endif

  assign out1 = out1_q;
  assign out2 = out2_q;
  assign out3 = out3_q;
  assign out4 = out4_q;

endmodule

`default_nettype wire

// File: tb/tb_thermo_quad_tx.sv
`default_nettype none

module tb_thermo_quad_tx;

  localparam int BIN_W = 4;
  localparam int TW    = 15;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [BIN_W-1:0] in_bin;
  logic             out_valid;
  logic             out_ready;
  logic [TW-1:0]    out1, out2, out3, out4;
`ifdef THERMO_EXPECT_EN
  logic [BIN_W-1:0] exp_second;
`endif

  int n_checks;
  int n_fail;

  thermo_quad_tx #(.BIN_W(BIN_W)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bin     (in_bin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .out4       (out4)
`ifdef THERMO_EXPECT_EN
    ,
    .exp_second (exp_second)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat after 'idle' empty cycles; returns just after the
  // accepting edge. Bounded wait on in_ready.
  task automatic send_beat(input logic [BIN_W-1:0] v, input int idle);
    bit done;
    for (int i = 0; i < idle; i++) tick();
    in_valid = 1'b1;
    in_bin   = v;
    done     = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    if (!done) check_eq("beat_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_set(input logic [BIN_W-1:0] a, input logic [BIN_W-1:0] b,
                          input logic [BIN_W-1:0] c, input logic [BIN_W-1:0] d,
                          input int idle);
    send_beat(a, idle);
    send_beat(b, idle);
    send_beat(c, idle);
    send_beat(d, idle);
  endtask

  task automatic check_set(input string tag,
                           input logic [TW-1:0] e1, input logic [TW-1:0] e2,
                           input logic [TW-1:0] e3, input logic [TW-1:0] e4,
                           input logic [BIN_W-1:0] e_exp);
    check_eq($sformatf("%s_valid", tag), 32'(out_valid), 32'd1);
    check_eq($sformatf("%s_ready", tag), 32'(in_ready), 32'd0);
    check_eq($sformatf("%s_out1", tag), 32'(out1), 32'(e1));
    check_eq($sformatf("%s_out2", tag), 32'(out2), 32'(e2));
    check_eq($sformatf("%s_out3", tag), 32'(out3), 32'(e3));
    check_eq($sformatf("%s_out4", tag), 32'(out4), 32'(e4));
`ifdef THERMO_EXPECT_EN
    check_eq($sformatf("%s_exp", tag), 32'(exp_second), 32'(e_exp));
`else
    if (e_exp == '1) n_checks = n_checks + 0;
`endif
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bin    = '0;
    out_ready = 1'b1;

    // 1: reset state
    #12;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out1", 32'(out1), 32'd0);
    check_eq("rst_out2", 32'(out2), 32'd0);
    check_eq("rst_out3", 32'(out3), 32'd0);
    check_eq("rst_out4", 32'(out4), 32'd0);
`ifdef THERMO_EXPECT_EN
    check_eq("rst_exp", 32'(exp_second), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 2: basic set, out_ready already high -> valid for exactly one cycle
    send_set(4'd4, 4'd6, 4'd5, 4'd4, 0);
    check_set("t2", 15'h000F, 15'h003F, 15'h001F, 15'h000F, 4'd5);
    tick();
    check_eq("t2_valid_drop", 32'(out_valid), 32'd0);
    check_eq("t2_ready_back", 32'(in_ready), 32'd1);
    check_eq("t2_out2_kept", 32'(out2), 32'h003F);

    // 3: boundary values
    send_set(4'd0, 4'd0, 4'd0, 4'd0, 0);
    check_set("t3a", 15'h0000, 15'h0000, 15'h0000, 15'h0000, 4'd0);
    tick();
    send_set(4'd15, 4'd15, 4'd15, 4'd15, 0);
    check_set("t3b", 15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF, 4'd15);
    tick();

    // 4: back-pressure with in_valid held high
    out_ready = 1'b0;
    send_set(4'd15, 4'd7, 4'd8, 4'd0, 0);
    in_valid = 1'b1;
    in_bin   = 4'd3;
    for (int i = 0; i < 5; i++) begin
      check_set($sformatf("t4_hold%0d", i), 15'h7FFF, 15'h007F, 15'h00FF, 15'h0000, 4'd8);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("t4_release_valid", 32'(out_valid), 32'd0);
    check_eq("t4_release_ready", 32'(in_ready), 32'd1);
    check_eq("t4_out3_kept", 32'(out3), 32'h00FF);

    // 6: idle cycles between beats; also proves nothing leaked in during hold
    send_set(4'd1, 4'd1, 4'd5, 4'd4, 3);
    check_set("t6", 15'h0001, 15'h0001, 15'h001F, 15'h000F, 4'd4);
    tick();
    check_eq("t6_valid_drop", 32'(out_valid), 32'd0);

    // 5: reset mid-collection discards partial lanes
    send_beat(4'd9, 0);
    send_beat(4'd3, 0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    send_set(4'd12, 4'd14, 4'd15, 4'd13, 0);
    check_set("t5", 15'h0FFF, 15'h3FFF, 15'h7FFF, 15'h1FFF, 4'd14);
    tick();

    // Reset while FULL drops out_valid asynchronously
    out_ready = 1'b0;
    send_set(4'd2, 4'd3, 4'd4, 4'd5, 0);
    check_eq("full_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 32'(out_valid), 32'd0);
    check_eq("async_rst_out1", 32'(out1), 32'd0);
    check_eq("async_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
